// File: rtl/aes128_package.sv
// Shared types and tower-field GF(((2^2)^2)^2) primitives for the S-box datapath.
// Representation: GF(4) = {e,f} -> e*W + f,  W^2 = W + 1
//                 GF(16) = {c,d} -> c*Z + d, Z^2 = Z + M, M = W
//                 GF(256) = {a,b} -> a*Y + b, Y^2 = Y + N, N = W*Z
package aes128_package;

   typedef logic [7:0] bv8_t;
   typedef logic [3:0] bv4_t;
   typedef logic [2:0] bv3_t;
   typedef logic [1:0] bv2_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} sqrt_state_t;

   localparam int SQRT_MAX_SQ = 7;

   // Field constants; both have trace 1, so each quadratic is irreducible.
   localparam bv2_t GF4_M  = 2'b10;
   localparam bv4_t GF16_N = 4'b1000;

   function automatic bv2_t gf4_mul(input bv2_t a, input bv2_t b);
      logic hh;
      hh = a[1] & b[1];
      return {hh ^ (a[1] & b[0]) ^ (a[0] & b[1]), hh ^ (a[0] & b[0])};
   endfunction

   function automatic bv2_t gf4_sq(input bv2_t a);
      return {a[1], a[1] ^ a[0]};
   endfunction

   function automatic bv2_t gf4_scl_m(input bv2_t a);
      return gf4_mul(a, GF4_M);
   endfunction

   function automatic bv4_t gf16_mul(input bv4_t a, input bv4_t b);
      bv2_t hh;
      hh = gf4_mul(a[3:2], b[3:2]);
      return {hh ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]),
              gf4_scl_m(hh) ^ gf4_mul(a[1:0], b[1:0])};
   endfunction

   // (c*Z + d)^2 = c^2*Z + (c^2*M + d^2)
   function automatic bv4_t gf16_sq(input bv4_t a);
      bv2_t s;
      s = gf4_sq(a[3:2]);
      return {s, gf4_scl_m(s) ^ gf4_sq(a[1:0])};
   endfunction

   function automatic bv4_t gf16_scl_n(input bv4_t a);
      return gf16_mul(a, GF16_N);
   endfunction

   // (a*Y + b)^2 = a^2*Y + (a^2*N + b^2)
   function automatic bv8_t bv8_square(input bv8_t x);
      bv4_t s;
      s = gf16_sq(x[7:4]);
      return {s, gf16_scl_n(s) ^ gf16_sq(x[3:0])};
   endfunction

endpackage

// File: rtl/bv8_sq.sv
// Combinational tower-field squaring of one bv8_t.
module bv8_sq
   import aes128_package::*;
(
   input  bv8_t in_x,
   output bv8_t out_y
);

   // Squaring is GF(2)-linear, so this reduces to a fixed XOR network.
   always_comb out_y = bv8_square(in_x);

endmodule

// File: rtl/bv8_sqrt_iter.sv
// Iterative Frobenius unit: computes x^(2^n), one squaring per clock.
// n = 7 gives the square root, since x^(2^8) = x in GF(256).
// Handshake: a transfer happens on a rising edge where the sender's valid
// and the receiver's ready are both 1. Upstream: in_valid/out_ready (operand);
// downstream: out_valid/in_ready (result). The result is held until taken.
module bv8_sqrt_iter
   import aes128_package::*;
#(
   parameter int MAX_SQ = SQRT_MAX_SQ
) (
   input  logic in_clock,
   input  logic in_reset,
   input  logic in_valid,
   output logic out_ready,
   input  bv8_t in_data,
   input  bv3_t in_count,
   output logic out_valid,
   input  logic in_ready,
   output bv8_t out_data,
   output logic out_busy
);

   localparam int CW = $clog2(MAX_SQ + 1);

   sqrt_state_t   state_q, state_d;
   bv8_t          acc_q, acc_d;
   bv8_t          acc_sq;
   bv8_t          out_data_q, out_data_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_in;
   logic          out_ready_q, out_ready_d;
   logic          out_valid_q, out_valid_d;
   logic          out_busy_q, out_busy_d;

   bv8_sq u_sq (
      .in_x  (acc_q),
      .out_y (acc_sq)
   );

   // Clamp the requested count to the largest supported number of squarings.
   always_comb begin
      if (int'(in_count) > MAX_SQ) cnt_in = CW'(MAX_SQ);
      else                         cnt_in = CW'(in_count);
   end

   // Next state, datapath and registered-output values.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               acc_d   = in_data;
               cnt_d   = cnt_in;
               state_d = (cnt_in == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            acc_d = acc_sq;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = DONE;
         end
         DONE: begin
            // out_valid is 1 here, so in_ready alone completes the transfer.
            if (in_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      out_ready_d = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      out_busy_d  = (state_d == RUN);
      // Capture the result only on entry to DONE so it stays put while held.
      if (state_d == DONE && state_q != DONE) out_data_d = acc_d;
      else                                   out_data_d = out_data_q;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge in_clock) begin
      if (in_reset) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_ready_q <= 1'b1;
         out_valid_q <= 1'b0;
         out_busy_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_ready_q <= out_ready_d;
         out_valid_q <= out_valid_d;
         out_busy_q  <= out_busy_d;
      end
   end

   assign out_ready = out_ready_q;
   assign out_valid = out_valid_q;
   assign out_busy  = out_busy_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_bv8_sqrt_iter.sv
// Self-checking bench for bv8_sqrt_iter: scoreboard of expected results,
// latency checks, hold/stability checks and reset behaviour.
module tb_bv8_sqrt_iter;
   import aes128_package::*;

   logic in_clock = 1'b0;
   logic in_reset;
   logic in_valid;
   logic out_ready;
   bv8_t in_data;
   bv3_t in_count;
   logic out_valid;
   logic in_ready;
   bv8_t out_data;
   logic out_busy;

   bv8_t m_x, m_y;
   bv8_t sqtab [256];
   bv8_t exp_q [$];
   int   n_tests = 0;
   int   n_fail  = 0;

   bv8_sqrt_iter dut (
      .in_clock  (in_clock),
      .in_reset  (in_reset),
      .in_valid  (in_valid),
      .out_ready (out_ready),
      .in_data   (in_data),
      .in_count  (in_count),
      .out_valid (out_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_busy  (out_busy)
   );

   // Reference squaring block, used only to fill sqtab.
   bv8_sq u_model (
      .in_x  (m_x),
      .out_y (m_y)
   );

   // Clock
   always #5 in_clock = ~in_clock;

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   function automatic bv8_t pow2n(input bv8_t x, input int n);
      bv8_t v;
      v = x;
      for (int i = 0; i < n; i++) v = sqtab[v];
      return v;
   endfunction

   // Offer one operand; returns 1 ns after the accepting edge.
   task automatic send(input bv8_t d, input bv3_t n, input bit push, input bv8_t e);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_count = n;
      while (!out_ready && guard < 40) begin
         @(negedge in_clock);
         guard++;
      end
      chk("accept_wait", 32'(guard < 40), 32'd1);
      @(posedge in_clock);
      if (push) exp_q.push_back(e);
      #1;
      in_valid = 1'b0;
   endtask

   // Wait for a result, check latency and data, optionally hold it for
   // `hold` cycles with in_ready low, then take it.
   task automatic recv(input string tag, input int exp_lat, input int hold, output bv8_t got);
      int   lat;
      bv8_t e;
      lat = 0;
      do begin
         @(negedge in_clock);
         lat++;
      end while (!out_valid && lat < 40);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      e   = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      got = out_data;
      chk({tag, "_data"}, 32'(out_data), 32'(e));
      for (int i = 0; i < hold; i++) begin
         @(negedge in_clock);
         chk({tag, "_hold_data"}, 32'(out_data), 32'(e));
         chk({tag, "_hold_ready"}, 32'(out_ready), 32'd0);
         chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      end
      in_ready = 1'b1;
      @(posedge in_clock);
      #1;
   endtask

   initial begin
      bv8_t r, r2;
      int   lat;
      bit   seen;
      in_reset = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_count = '0;
      in_ready = 1'b1;
      m_x      = '0;

      // Build the squaring table from the reference block.
      for (int i = 0; i < 256; i++) begin
         m_x = 8'(i);
         #1;
         sqtab[i] = m_y;
      end

      // Reset, then observe idle outputs.
      @(posedge in_clock);
      @(posedge in_clock);
      #1;
      in_reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge in_clock);
         chk("rst_ready", 32'(out_ready), 32'd1);
         chk("rst_valid", 32'(out_valid), 32'd0);
         chk("rst_data", 32'(out_data), 32'h00);
         chk("rst_busy", 32'(out_busy), 32'd0);
      end
      @(posedge in_clock);
      #1;

      // n = 0 with downstream stalled for 5 cycles.
      in_ready = 1'b0;
      send(8'hA5, 3'd0, 1'b1, 8'hA5);
      recv("n0_hold", 1, 5, r);

      // Fixed points of squaring.
      send(8'h01, 3'd7, 1'b1, 8'h01);
      recv("one_n7", 8, 0, r);
      send(8'h00, 3'd7, 1'b1, 8'h00);
      recv("zero_n7", 8, 0, r);

      // Square root of every element, then square it back.
      for (int x = 0; x < 256; x++) begin
         send(8'(x), 3'd7, 1'b1, pow2n(8'(x), 7));
         recv("sqrt_n7", 8, 0, r);
         send(r, 3'd1, 1'b1, 8'(x));
         recv("back_n1", 2, 0, r2);
      end

      // Random operands and counts.
      for (int k = 0; k < 24; k++) begin
         int   n;
         bv8_t x;
         n = $urandom_range(0, 7);
         x = 8'($urandom_range(0, 255));
         send(x, 3'(n), 1'b1, pow2n(x, n));
         recv("rand", n + 1, 0, r);
      end

      // Reset two cycles into a 3-squaring run: result discarded.
      send(8'h77, 3'd3, 1'b0, 8'h00);
      @(posedge in_clock);
      #1;
      in_reset = 1'b1;
      @(posedge in_clock);
      #1;
      in_reset = 1'b0;
      @(negedge in_clock);
      chk("midrst_ready", 32'(out_ready), 32'd1);
      chk("midrst_busy", 32'(out_busy), 32'd0);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge in_clock);
         chk("midrst_no_pulse", 32'(out_valid), 32'd0);
      end
      @(posedge in_clock);
      #1;

      // Reset together with an offered operand: reset wins.
      in_valid = 1'b1;
      in_data  = 8'h99;
      in_count = 3'd0;
      in_reset = 1'b1;
      @(posedge in_clock);
      #1;
      in_valid = 1'b0;
      in_reset = 1'b0;
      @(negedge in_clock);
      chk("rstvalid_valid", 32'(out_valid), 32'd0);
      chk("rstvalid_ready", 32'(out_ready), 32'd1);
      @(posedge in_clock);
      #1;

      send(8'h3C, 3'd0, 1'b1, 8'h3C);
      recv("after_rst", 1, 0, r);

      // in_valid held high with changing data through RUN and DONE.
      in_ready = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h5A;
      in_count = 3'd7;
      @(posedge in_clock);
      exp_q.push_back(pow2n(8'h5A, 7));
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge in_clock);
         lat++;
         if (out_valid) seen = 1'b1;
         else begin
            in_data  = 8'($urandom_range(0, 255));
            in_count = 3'($urandom_range(0, 7));
         end
      end
      chk("held_lat", 32'(lat), 32'd8);
      r = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      chk("held_data", 32'(out_data), 32'(r));
      for (int i = 0; i < 2; i++) begin
         in_data = 8'($urandom_range(0, 255));
         @(negedge in_clock);
         chk("held_done_ready", 32'(out_ready), 32'd0);
         chk("held_done_data", 32'(out_data), 32'(r));
      end
      in_valid = 1'b0;
      in_ready = 1'b1;
      @(posedge in_clock);
      #1;
      for (int i = 0; i < 4; i++) begin
         @(negedge in_clock);
         chk("held_single", 32'(out_valid), 32'd0);
         chk("held_idle_busy", 32'(out_busy), 32'd0);
      end

      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
